// File: rtl/mem_if_checker_pkg.sv
// Shared types and strobe helpers for the multi-channel req/gnt memory interface checker.
package mem_if_checker_pkg;

    typedef enum logic [1:0] {
        VIOL_STABLE  = 2'd0,
        VIOL_TIMEOUT = 2'd1,
        VIOL_ALIGN   = 2'd2,
        VIOL_STRB    = 2'd3
    } viol_kind_t;

    typedef enum logic {
        STALL_IDLE = 1'b0,
        STALL_WAIT = 1'b1
    } stall_state_t;

    // Widest strobe the helpers accept; narrower strobes are zero-extended.
    localparam int STRB_MAX = 64;

    // Nonzero and a single run of ones: adding the lowest set bit clears the whole run.
    function automatic logic strb_legal(input logic [STRB_MAX-1:0] s);
        logic [STRB_MAX-1:0] low_s;
        low_s = s & (~s + 64'd1);
        return (s != 64'd0) && (((s + low_s) & s) == 64'd0);
    endfunction

    function automatic logic [7:0] strb_popcount(input logic [STRB_MAX-1:0] s);
        logic [7:0] cnt_s;
        cnt_s = 8'd0;
        for (int i = 0; i < STRB_MAX; i++) begin
            cnt_s = cnt_s + {7'd0, s[i]};
        end
        return cnt_s;
    endfunction

    function automatic logic [7:0] strb_lsb_idx(input logic [STRB_MAX-1:0] s);
        logic [7:0] idx_s;
        idx_s = 8'd0;
        for (int i = STRB_MAX - 1; i >= 0; i--) begin
            if (s[i]) begin
                idx_s = 8'(i);
            end else begin
                idx_s = idx_s;
            end
        end
        return idx_s;
    endfunction

    function automatic viol_kind_t det_to_kind(input logic [3:0] det);
        viol_kind_t kind_s;
        if (det[0]) begin
            kind_s = VIOL_STABLE;
        end else if (det[1]) begin
            kind_s = VIOL_TIMEOUT;
        end else if (det[2]) begin
            kind_s = VIOL_ALIGN;
        end else begin
            kind_s = VIOL_STRB;
        end
        return kind_s;
    endfunction

endpackage

// File: rtl/mem_if_checker_chan.sv
// One observed channel: stall FSM, rule checks, sticky flags and saturating counters.
// Concurrent assertions/covers are added when MEM_IF_CHECKER_ASSERT_EN is defined.
module mem_if_checker_chan
    import mem_if_checker_pkg::*;
#(
    parameter int  AW        = 64,
    parameter int  DW        = 64,
    parameter int  MAX_STALL = 15,
    parameter int  CW        = 16,
    localparam int SW        = DW / 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          req,
    input  logic [AW-1:0] addr,
    input  logic          wen,
    input  logic [SW-1:0] strb,
    input  logic [DW-1:0] wdata,
    input  logic          gnt,
    input  logic          err,
    output logic          viol_stable,
    output logic          viol_timeout,
    output logic          viol_align,
    output logic          viol_strb,
    output logic [3:0]    det,
    output logic [CW-1:0] txn_count,
    output logic [CW-1:0] err_count
);

    localparam int             SCW       = $clog2(MAX_STALL + 2);
    localparam logic [SCW-1:0] STALL_SAT = SCW'(MAX_STALL + 1);

    stall_state_t        state_r;
    stall_state_t        state_nxt_s;
    logic [SCW-1:0]      stall_cnt_r;
    logic [SCW-1:0]      stall_cnt_nxt_s;
    logic                capture_s;
    logic [AW-1:0]       addr_r;
    logic                wen_r;
    logic [SW-1:0]       strb_r;
    logic [DW-1:0]       wdata_r;
    logic [STRB_MAX-1:0] strb_ext_s;
    logic [7:0]          strb_pop_s;
    logic [7:0]          strb_lsb_s;
    logic                size_ok_s;
    logic                align_ok_s;
    logic                det_stable_s;
    logic                det_timeout_s;
    logic                det_align_s;
    logic                det_strb_s;

    // Stall FSM next state and stall-length counter
    always_comb begin
        state_nxt_s     = state_r;
        stall_cnt_nxt_s = stall_cnt_r;
        capture_s       = 1'b0;
        case (state_r)
            STALL_IDLE: begin
                if (req && !gnt) begin
                    state_nxt_s     = STALL_WAIT;
                    stall_cnt_nxt_s = SCW'(1'b1);
                    capture_s       = 1'b1;
                end else begin
                    stall_cnt_nxt_s = '0;
                end
            end
            STALL_WAIT: begin
                if (gnt || !req) begin
                    state_nxt_s     = STALL_IDLE;
                    stall_cnt_nxt_s = '0;
                end else if (stall_cnt_r != STALL_SAT) begin
                    stall_cnt_nxt_s = stall_cnt_r + SCW'(1'b1);
                end else begin
                    stall_cnt_nxt_s = stall_cnt_r;
                end
            end
            default: begin
                state_nxt_s     = STALL_IDLE;
                stall_cnt_nxt_s = '0;
            end
        endcase
    end

    // Rule checks evaluated on the current inputs
    always_comb begin
        strb_ext_s = STRB_MAX'(strb);
        strb_pop_s = strb_popcount(strb_ext_s);
        strb_lsb_s = strb_lsb_idx(strb_ext_s);
        size_ok_s  = (strb_pop_s == 8'd1) || (strb_pop_s == 8'd2) ||
                     (strb_pop_s == 8'd4) || (strb_pop_s == 8'd8);
        // Reads carry no meaningful strobe, so only word alignment is checked.
        if (wen) begin
            align_ok_s = size_ok_s && (strb_lsb_s == {5'd0, addr[2:0]});
        end else begin
            align_ok_s = (addr[1:0] == 2'b00);
        end
        if (state_r == STALL_WAIT) begin
            det_stable_s = !req || (addr != addr_r) || (wen != wen_r) ||
                           (wen_r && ((wdata != wdata_r) || (strb != strb_r)));
        end else begin
            det_stable_s = 1'b0;
        end
        det_timeout_s = req && !gnt && (stall_cnt_nxt_s == STALL_SAT);
        det_align_s   = req && !align_ok_s;
        det_strb_s    = req && wen && !strb_legal(strb_ext_s);
        det           = {det_strb_s, det_align_s, det_timeout_s, det_stable_s};
    end

    // FSM state, stall counter and copy of the stalled request
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r     <= STALL_IDLE;
            stall_cnt_r <= '0;
            addr_r      <= '0;
            wen_r       <= 1'b0;
            strb_r      <= '0;
            wdata_r     <= '0;
        end else begin
            state_r     <= state_nxt_s;
            stall_cnt_r <= stall_cnt_nxt_s;
            if (capture_s) begin
                addr_r  <= addr;
                wen_r   <= wen;
                strb_r  <= strb;
                wdata_r <= wdata;
            end
        end
    end

    // Sticky violation flags and saturating completion/error counters
    always_ff @(posedge clk) begin
        if (!resetn) begin
            viol_stable  <= 1'b0;
            viol_timeout <= 1'b0;
            viol_align   <= 1'b0;
            viol_strb    <= 1'b0;
            txn_count    <= '0;
            err_count    <= '0;
        end else begin
            viol_stable  <= viol_stable  | det_stable_s;
            viol_timeout <= viol_timeout | det_timeout_s;
            viol_align   <= viol_align   | det_align_s;
            viol_strb    <= viol_strb    | det_strb_s;
            if (req && gnt && (txn_count != '1)) begin
                txn_count <= txn_count + CW'(1'b1);
            end
            if (req && gnt && err && (err_count != '1)) begin
                err_count <= err_count + CW'(1'b1);
            end
        end
    end

`ifdef MEM_IF_CHECKER_ASSERT_EN
    mem_if_checker_chan_sva #(
        .MAX_STALL (MAX_STALL),
        .SCW       (SCW)
    ) u_sva (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req),
        .wen        (wen),
        .gnt        (gnt),
        .err        (err),
        .stall_wait (state_r == STALL_WAIT),
        .stall_cnt  (stall_cnt_r),
        .det        (det)
    );
`else
    // Flag and counter logic only.
`endif

endmodule

`ifdef MEM_IF_CHECKER_ASSERT_EN
// Property checker bound to one channel's rule detectors.
module mem_if_checker_chan_sva #(
    parameter int MAX_STALL = 15,
    parameter int SCW       = 5
) (
    input logic           clk,
    input logic           resetn,
    input logic           req,
    input logic           wen,
    input logic           gnt,
    input logic           err,
    input logic           stall_wait,
    input logic [SCW-1:0] stall_cnt,
    input logic [3:0]     det
);
    a_stable:  assert property (@(posedge clk) disable iff (!resetn) !det[0]);
    a_timeout: assert property (@(posedge clk) disable iff (!resetn) !det[1]);
    a_align:   assert property (@(posedge clk) disable iff (!resetn) !det[2]);
    a_strb:    assert property (@(posedge clk) disable iff (!resetn) !det[3]);

    c_stall_max: cover property (@(posedge clk) disable iff (!resetn)
        stall_wait && (stall_cnt == SCW'(MAX_STALL)) && req && gnt);
    c_err_rsp:   cover property (@(posedge clk) disable iff (!resetn) req && gnt && err);
    c_wr_done:   cover property (@(posedge clk) disable iff (!resetn) req && gnt && wen);
endmodule
`endif

// File: rtl/mem_if_checker.sv
// Multi-channel req/gnt memory interface checker: per-channel observers, OR reduction
// and first-violation capture. MEM_IF_CHECKER_ASSERT_EN adds per-channel assertions.
module mem_if_checker
    import mem_if_checker_pkg::*;
#(
    parameter int  CHANNELS  = 2,
    parameter int  AW        = 64,
    parameter int  DW        = 64,
    parameter int  MAX_STALL = 15,
    parameter int  CW        = 16,
    localparam int CHW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                     f_clk,
    input  logic                     g_resetn,
    input  logic [CHANNELS-1:0]      mem_req,
    input  logic [CHANNELS*AW-1:0]   mem_addr,
    input  logic [CHANNELS-1:0]      mem_wen,
    input  logic [CHANNELS*DW/8-1:0] mem_strb,
    input  logic [CHANNELS*DW-1:0]   mem_wdata,
    input  logic [CHANNELS-1:0]      mem_gnt,
    input  logic [CHANNELS-1:0]      mem_err,
    output logic [CHANNELS-1:0]      viol_stable,
    output logic [CHANNELS-1:0]      viol_timeout,
    output logic [CHANNELS-1:0]      viol_align,
    output logic [CHANNELS-1:0]      viol_strb,
    output logic                     any_viol,
    output logic                     first_valid,
    output logic [CHW-1:0]           first_ch,
    output viol_kind_t               first_kind,
    output logic [CHANNELS*CW-1:0]   txn_count,
    output logic [CHANNELS*CW-1:0]   err_count
);

    localparam int SW = DW / 8;

    logic [3:0]     det_s [CHANNELS];
    logic           hit_s;
    logic [CHW-1:0] hit_ch_s;
    viol_kind_t     hit_kind_s;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        mem_if_checker_chan #(
            .AW        (AW),
            .DW        (DW),
            .MAX_STALL (MAX_STALL),
            .CW        (CW)
        ) u_chan (
            .clk          (f_clk),
            .resetn       (g_resetn),
            .req          (mem_req[g]),
            .addr         (mem_addr[g*AW +: AW]),
            .wen          (mem_wen[g]),
            .strb         (mem_strb[g*SW +: SW]),
            .wdata        (mem_wdata[g*DW +: DW]),
            .gnt          (mem_gnt[g]),
            .err          (mem_err[g]),
            .viol_stable  (viol_stable[g]),
            .viol_timeout (viol_timeout[g]),
            .viol_align   (viol_align[g]),
            .viol_strb    (viol_strb[g]),
            .det          (det_s[g]),
            .txn_count    (txn_count[g*CW +: CW]),
            .err_count    (err_count[g*CW +: CW])
        );
    end

    // Lowest-indexed channel with a fresh violation this cycle, with its top-priority kind
    always_comb begin
        hit_s      = 1'b0;
        hit_ch_s   = '0;
        hit_kind_s = VIOL_STABLE;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!hit_s && (det_s[i] != 4'b0000)) begin
                hit_s      = 1'b1;
                hit_ch_s   = CHW'(i);
                hit_kind_s = det_to_kind(det_s[i]);
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // Global violation summary and first-violation capture
    always_ff @(posedge f_clk) begin
        if (!g_resetn) begin
            any_viol    <= 1'b0;
            first_valid <= 1'b0;
            first_ch    <= '0;
            first_kind  <= VIOL_STABLE;
        end else begin
            any_viol <= any_viol | hit_s;
            if (!first_valid && hit_s) begin
                first_valid <= 1'b1;
                first_ch    <= hit_ch_s;
                first_kind  <= hit_kind_s;
            end
        end
    end

endmodule

// File: tb/tb_mem_if_checker.sv
// Scoreboard bench for mem_if_checker: a reference model predicts every output per cycle.
module tb_mem_if_checker;
    import mem_if_checker_pkg::*;

    localparam int CH  = 2;
    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int SW  = DW / 8;
    localparam int MS  = 15;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic             clk = 1'b0;
    logic             g_resetn;
    logic [CH-1:0]    mem_req, mem_wen, mem_gnt, mem_err;
    logic [CH*AW-1:0] mem_addr;
    logic [CH*SW-1:0] mem_strb;
    logic [CH*DW-1:0] mem_wdata;
    logic [CH-1:0]    viol_stable, viol_timeout, viol_align, viol_strb;
    logic             any_viol, first_valid;
    logic [0:0]       first_ch;
    viol_kind_t       first_kind;
    logic [CH*CW-1:0] txn_count, err_count;

    always #5 clk = ~clk;

    mem_if_checker #(
        .CHANNELS (CH), .AW (AW), .DW (DW), .MAX_STALL (MS), .CW (CW)
    ) dut (
        .f_clk (clk), .g_resetn (g_resetn),
        .mem_req (mem_req), .mem_addr (mem_addr), .mem_wen (mem_wen), .mem_strb (mem_strb),
        .mem_wdata (mem_wdata), .mem_gnt (mem_gnt), .mem_err (mem_err),
        .viol_stable (viol_stable), .viol_timeout (viol_timeout), .viol_align (viol_align),
        .viol_strb (viol_strb), .any_viol (any_viol), .first_valid (first_valid),
        .first_ch (first_ch), .first_kind (first_kind),
        .txn_count (txn_count), .err_count (err_count)
    );

    typedef struct packed {
        logic [CH-1:0]    st, to, al, sb;
        logic             any, fv, fch;
        logic [1:0]       fk;
        logic [CH*CW-1:0] txn, ec;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    logic          m_stall [CH];
    int            m_cnt   [CH];
    logic [AW-1:0] m_addr  [CH];
    logic          m_wen   [CH];
    logic [SW-1:0] m_strb  [CH];
    logic [DW-1:0] m_wdata [CH];
    logic [CH-1:0] e_st, e_to, e_al, e_sb;
    logic          e_fv, e_fch;
    logic [1:0]    e_fk;
    int            e_txn [CH];
    int            e_err [CH];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic bit contiguous(input logic [SW-1:0] s);
        int   runs = 0;
        logic prev = 1'b0;
        for (int i = 0; i < SW; i++) begin
            if (s[i] && !prev) runs++;
            prev = s[i];
        end
        return runs == 1;
    endfunction

    function automatic int lowest_bit(input logic [SW-1:0] s);
        for (int i = 0; i < SW; i++) if (s[i]) return i;
        return 0;
    endfunction

    task automatic model_step();
        logic [3:0] d [CH];
        if (!g_resetn) begin
            for (int c = 0; c < CH; c++) begin
                m_stall[c] = 1'b0; m_cnt[c] = 0; e_txn[c] = 0; e_err[c] = 0;
                m_addr[c] = '0; m_wen[c] = 1'b0; m_strb[c] = '0; m_wdata[c] = '0;
            end
            e_st = '0; e_to = '0; e_al = '0; e_sb = '0;
            e_fv = 1'b0; e_fch = 1'b0; e_fk = 2'd0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                logic r, w, g;
                logic [AW-1:0] a;
                logic [SW-1:0] s;
                logic [DW-1:0] wd;
                int nxt, pc;
                r = mem_req[c]; w = mem_wen[c]; g = mem_gnt[c];
                a = mem_addr[c*AW +: AW]; s = mem_strb[c*SW +: SW]; wd = mem_wdata[c*DW +: DW];
                d[c] = 4'b0000;
                if (m_stall[c] && (!r || a != m_addr[c] || w != m_wen[c] ||
                    (m_wen[c] && (wd != m_wdata[c] || s != m_strb[c])))) d[c][0] = 1'b1;
                nxt = m_stall[c] ? m_cnt[c] + 1 : 1;
                if (nxt > MS + 1) nxt = MS + 1;
                if (r && !g && nxt == MS + 1) d[c][1] = 1'b1;
                pc = $countones(s);
                if (r && w && !((pc == 1 || pc == 2 || pc == 4 || pc == 8) &&
                    lowest_bit(s) == int'(a[2:0]))) d[c][2] = 1'b1;
                if (r && !w && a[1:0] != 2'b00) d[c][2] = 1'b1;
                if (r && w && !contiguous(s)) d[c][3] = 1'b1;
                if (r && !g) begin
                    if (!m_stall[c]) begin
                        m_stall[c] = 1'b1; m_addr[c] = a; m_wen[c] = w; m_strb[c] = s; m_wdata[c] = wd;
                    end
                    m_cnt[c] = nxt;
                end else begin
                    m_stall[c] = 1'b0; m_cnt[c] = 0;
                end
                if (r && g) begin
                    if (e_txn[c] < SAT) e_txn[c]++;
                    if (mem_err[c] && e_err[c] < SAT) e_err[c]++;
                end
                e_st[c] |= d[c][0]; e_to[c] |= d[c][1]; e_al[c] |= d[c][2]; e_sb[c] |= d[c][3];
            end
            for (int c = 0; c < CH; c++) begin
                if (!e_fv && d[c] != 4'b0000) begin
                    e_fv = 1'b1; e_fch = c[0];
                    e_fk = d[c][0] ? 2'd0 : d[c][1] ? 2'd1 : d[c][2] ? 2'd2 : 2'd3;
                end
            end
        end
    endtask

    task automatic compare_pop();
        exp_t e;
        check_eq("sb_depth", 64'(sb_q.size()), 64'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("viol_stable",  64'(viol_stable),  64'(e.st));
            check_eq("viol_timeout", 64'(viol_timeout), 64'(e.to));
            check_eq("viol_align",   64'(viol_align),   64'(e.al));
            check_eq("viol_strb",    64'(viol_strb),    64'(e.sb));
            check_eq("any_viol",     64'(any_viol),     64'(e.any));
            check_eq("first_valid",  64'(first_valid),  64'(e.fv));
            check_eq("first_ch",     64'(first_ch),     64'(e.fch));
            check_eq("first_kind",   64'(first_kind),   64'(e.fk));
            check_eq("txn_count",    64'(txn_count),    64'(e.txn));
            check_eq("err_count",    64'(err_count),    64'(e.ec));
        end
    endtask

    task automatic step();
        exp_t e;
        model_step();
        e.st = e_st; e.to = e_to; e.al = e_al; e.sb = e_sb;
        e.any = |{e_st, e_to, e_al, e_sb};
        e.fv = e_fv; e.fch = e_fch; e.fk = e_fk;
        for (int c = 0; c < CH; c++) begin
            e.txn[c*CW +: CW] = CW'(e_txn[c]);
            e.ec[c*CW +: CW]  = CW'(e_err[c]);
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare_pop();
    endtask

    task automatic drive(input int c, input logic r, input logic w, input logic [AW-1:0] a,
                         input logic [SW-1:0] s, input logic [DW-1:0] wd,
                         input logic g, input logic er);
        mem_req[c] = r; mem_wen[c] = w; mem_gnt[c] = g; mem_err[c] = er;
        mem_addr[c*AW +: AW] = a; mem_strb[c*SW +: SW] = s; mem_wdata[c*DW +: DW] = wd;
    endtask

    task automatic idle_all();
        for (int c = 0; c < CH; c++) drive(c, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic reset_dut();
        idle_all();
        g_resetn = 1'b0;
        step();
        step();
        g_resetn = 1'b1;
    endtask

    logic [SW-1:0] rnd_strb [9] = '{8'h01, 8'h02, 8'h0C, 8'h0C, 8'hF0, 8'hFF, 8'h05, 8'h00, 8'h03};
    logic [2:0]    rnd_low  [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0};

    initial begin
        g_resetn = 1'b0;
        idle_all();
        reset_dut();
        check_eq("rst_any_viol", 64'(any_viol), 64'd0);
        check_eq("rst_txn", 64'(txn_count), 64'd0);

        // Stable read, grant on 3rd cycle
        drive(0, 1'b1, 1'b0, 64'h1000, 8'h00, 64'd0, 1'b0, 1'b0);
        step(); step();
        mem_gnt[0] = 1'b1;
        step();
        idle_all();
        step();
        check_eq("rd_txn0", 64'(txn_count[CW-1:0]), 64'd1);
        check_eq("rd_no_viol", 64'(any_viol), 64'd0);

        // Write whose data changes on the 2nd stall cycle
        reset_dut();
        drive(1, 1'b1, 1'b1, 64'h2000, 8'hFF, 64'hA5A5, 1'b0, 1'b0);
        step();
        mem_wdata[DW +: DW] = 64'h5A5A;
        step();
        check_eq("stab_flag1", 64'(viol_stable[1]), 64'd1);
        check_eq("stab_first_ch", 64'(first_ch), 64'd1);
        check_eq("stab_first_kind", 64'(first_kind), 64'd0);
        mem_gnt[1] = 1'b1;
        step();
        idle_all();
        step();

        // 15-cycle stall is legal, 16-cycle stall times out
        reset_dut();
        drive(0, 1'b1, 1'b0, 64'h40, 8'h00, 64'd0, 1'b0, 1'b0);
        repeat (MS) step();
        mem_gnt[0] = 1'b1;
        step();
        idle_all();
        step();
        check_eq("stall15_timeout", 64'(viol_timeout[0]), 64'd0);
        drive(0, 1'b1, 1'b0, 64'h40, 8'h00, 64'd0, 1'b0, 1'b0);
        repeat (MS) step();
        check_eq("stall15b_timeout", 64'(viol_timeout[0]), 64'd0);
        step();
        check_eq("stall16_timeout", 64'(viol_timeout[0]), 64'd1);
        check_eq("stall16_kind", 64'(first_kind), 64'd1);
        mem_gnt[0] = 1'b1;
        step();
        idle_all();
        step();

        // Alignment and strobe legality
        reset_dut();
        drive(0, 1'b1, 1'b1, 64'h103, 8'h0C, 64'd1, 1'b1, 1'b0);
        step();
        idle_all();
        check_eq("strb0C_align", 64'(viol_align[0]), 64'd1);
        check_eq("strb0C_strb", 64'(viol_strb[0]), 64'd0);
        reset_dut();
        drive(0, 1'b1, 1'b1, 64'h100, 8'h05, 64'd1, 1'b1, 1'b0);
        step();
        idle_all();
        check_eq("strb05_strb", 64'(viol_strb[0]), 64'd1);
        check_eq("strb05_align", 64'(viol_align[0]), 64'd0);
        reset_dut();
        drive(0, 1'b1, 1'b1, 64'h100, 8'h00, 64'd1, 1'b1, 1'b0);
        step();
        idle_all();
        check_eq("strb00_strb", 64'(viol_strb[0]), 64'd1);
        check_eq("strb00_align", 64'(viol_align[0]), 64'd1);

        // Same-cycle violations on both channels
        reset_dut();
        drive(0, 1'b1, 1'b1, 64'h200, 8'h05, 64'd7, 1'b1, 1'b0);
        drive(1, 1'b1, 1'b0, 64'h1002, 8'h00, 64'd0, 1'b1, 1'b0);
        step();
        idle_all();
        check_eq("simul_first_ch", 64'(first_ch), 64'd0);
        check_eq("simul_first_kind", 64'(first_kind), 64'd3);
        check_eq("simul_align1", 64'(viol_align[1]), 64'd1);
        check_eq("simul_strb0", 64'(viol_strb[0]), 64'd1);

        // Counter saturation
        reset_dut();
        drive(0, 1'b1, 1'b0, 64'h0, 8'h00, 64'd0, 1'b1, 1'b1);
        drive(1, 1'b1, 1'b1, 64'h8, 8'hFF, 64'd3, 1'b1, 1'b1);
        repeat (20) step();
        idle_all();
        check_eq("sat_txn", 64'(txn_count), 64'hFF);
        check_eq("sat_err", 64'(err_count), 64'hFF);

        // Reset in the middle of a stall
        reset_dut();
        drive(0, 1'b1, 1'b1, 64'h300, 8'hFF, 64'd9, 1'b0, 1'b0);
        repeat (5) step();
        g_resetn = 1'b0;
        step();
        g_resetn = 1'b1;
        idle_all();
        step();
        check_eq("midrst_any", 64'(any_viol), 64'd0);
        check_eq("midrst_fv", 64'(first_valid), 64'd0);
        check_eq("midrst_txn", 64'(txn_count), 64'd0);

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            if (n % 40 == 0) begin
                g_resetn = 1'b0;
            end else begin
                g_resetn = 1'b1;
            end
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 3) == 0) begin
                    int k;
                    k = $urandom_range(0, 8);
                    mem_req[c]  = ($urandom_range(0, 3) != 0);
                    mem_wen[c]  = $urandom_range(0, 1) == 1;
                    mem_addr[c*AW +: AW]  = {$urandom, $urandom[28:0], rnd_low[k]};
                    mem_strb[c*SW +: SW]  = rnd_strb[k];
                    mem_wdata[c*DW +: DW] = {$urandom, $urandom};
                end
                mem_gnt[c] = ($urandom_range(0, 2) == 0);
                mem_err[c] = ($urandom_range(0, 3) == 0);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
